// File: rtl/tea_pkg.sv
// Shared constants, state enumeration and mode encoding for the TEA round scheduler.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA  = 32'h9E3779B9;
    localparam int          TEA_ROUNDS = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUM  = 3'd1,
        RES  = 3'd2,
        VUPD = 3'd3,
        DONE = 3'd4
    } tea_state_t;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } tea_mode_t;

    // Starting sum for decryption: the sum an encryption would end on.
    function automatic logic [31:0] dec_sum_init(input logic [31:0] delta, input int unsigned rounds);
        logic [63:0] prod;
        prod = 64'(delta) * 64'(rounds);
        return prod[31:0];
    endfunction

endpackage

// File: rtl/tea_rr_arb.sv
// Two-way round-robin arbiter: picks a winner among the requests and remembers the last grant.
module tea_rr_arb (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] winner
);

    logic last_gnt;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last_gnt ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt <= 1'b1;
        end else if (take && (req != 2'b00)) begin
            last_gnt <= winner[1];
        end
    end

endmodule

// File: rtl/tea_round_scheduler.sv
// Round scheduler for a shared TEA datapath: arbitrates two requesters and sequences the per-round strobes.
module tea_round_scheduler
    import tea_pkg::*;
#(
    parameter int          ROUNDS = TEA_ROUNDS,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req,
    input  logic [1:0]  req_mode,
    input  logic        abort,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        ld_sum_enc,
    output logic        ld_sum_dec,
    output logic        ld_results,
    output logic        ld_v_enc,
    output logic        ld_v_dec,
    output logic [31:0] sum,
    output logic [5:0]  round,
    output logic [1:0]  done
);

    localparam logic [5:0]  ROUNDS_W     = 6'(ROUNDS);
    localparam logic [31:0] SUM_DEC_INIT = dec_sum_init(DELTA, ROUNDS);

    tea_state_t state, state_next;
    tea_mode_t  mode;
    logic [1:0] winner;
    logic       grant;
    logic       abort_clr;
    logic [5:0] round_inc;
    tea_mode_t  win_mode;

    tea_rr_arb u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .take   (grant),
        .winner (winner)
    );

    assign round_inc = round + 6'd1;
    assign win_mode  = tea_mode_t'(req_mode[winner[1]]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Encrypt runs SUM->RES->VUPD per round; decrypt runs RES->VUPD->SUM.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        abort_clr  = 1'b0;
        busy       = (state != IDLE);
        ld_sum_enc = 1'b0;
        ld_sum_dec = 1'b0;
        ld_results = 1'b0;
        ld_v_enc   = 1'b0;
        ld_v_dec   = 1'b0;
        done       = 2'b00;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    grant      = 1'b1;
                    state_next = (win_mode == DEC) ? RES : SUM;
                end
            end
            SUM: begin
                ld_sum_enc = (mode == ENC);
                ld_sum_dec = (mode == DEC);
                if (mode == ENC) begin
                    state_next = RES;
                end else begin
                    state_next = (round_inc == ROUNDS_W) ? DONE : RES;
                end
            end
            RES: begin
                ld_results = 1'b1;
                state_next = VUPD;
            end
            VUPD: begin
                ld_v_enc = (mode == ENC);
                ld_v_dec = (mode == DEC);
                if (mode == ENC) begin
                    state_next = (round == ROUNDS_W) ? DONE : SUM;
                end else begin
                    state_next = SUM;
                end
            end
            DONE: begin
                done       = gnt;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort && (state inside {SUM, RES, VUPD})) begin
            state_next = IDLE;
            abort_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt   <= 2'b00;
            mode  <= ENC;
            sum   <= 32'd0;
            round <= 6'd0;
        end else if (abort_clr) begin
            gnt   <= 2'b00;
            sum   <= 32'd0;
            round <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt   <= winner;
                        mode  <= win_mode;
                        round <= 6'd0;
                        sum   <= (win_mode == DEC) ? SUM_DEC_INIT : 32'd0;
                    end
                end
                SUM: begin
                    round <= round_inc;
                    sum   <= (mode == ENC) ? (sum + DELTA) : (sum - DELTA);
                end
                DONE:    gnt <= 2'b00;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_round_scheduler.sv
// Scoreboard bench for tea_round_scheduler: random and directed jobs checked against a job-level model.
module tb_tea_round_scheduler;

    localparam int          R     = 32;
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic        clk;
    logic        resetn;
    logic [1:0]  req, req_mode;
    logic        abort;
    logic [1:0]  gnt, done;
    logic        busy, ld_sum_enc, ld_sum_dec, ld_results, ld_v_enc, ld_v_dec;
    logic [31:0] sum;
    logic [5:0]  round;

    logic [1:0]  r1_req, r1_req_mode;
    logic [1:0]  r1_gnt, r1_done;
    logic        r1_busy, r1_se, r1_sd, r1_res, r1_ve, r1_vd;
    logic [31:0] r1_sum;
    logic [5:0]  r1_round;

    tea_round_scheduler #(.ROUNDS(R), .DELTA(DELTA)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_mode(req_mode), .abort(abort),
        .gnt(gnt), .busy(busy), .ld_sum_enc(ld_sum_enc), .ld_sum_dec(ld_sum_dec),
        .ld_results(ld_results), .ld_v_enc(ld_v_enc), .ld_v_dec(ld_v_dec),
        .sum(sum), .round(round), .done(done)
    );

    tea_round_scheduler #(.ROUNDS(1), .DELTA(DELTA)) dut_r1 (
        .clk(clk), .resetn(resetn), .req(r1_req), .req_mode(r1_req_mode), .abort(1'b0),
        .gnt(r1_gnt), .busy(r1_busy), .ld_sum_enc(r1_se), .ld_sum_dec(r1_sd),
        .ld_results(r1_res), .ld_v_enc(r1_ve), .ld_v_dec(r1_vd),
        .sum(r1_sum), .round(r1_round), .done(r1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic mode;
        logic expect_done;
    } job_t;

    job_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   viol = 0;
    int   model_last = 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: TEA sum after r encryption rounds, and after r further decryption rounds.
    function automatic logic [31:0] model_enc_sum(input int r);
        logic [31:0] s = 32'd0;
        repeat (r) s = s + DELTA;
        return s;
    endfunction

    function automatic logic [31:0] model_dec_final(input int r);
        logic [31:0] s = model_enc_sum(r);
        repeat (r) s = s - DELTA;
        return s;
    endfunction

    // Monitor: tracks one job at a time, compares against the scoreboard head.
    int   cyc = 0, grant_cyc = 0;
    int   cnt_se, cnt_sd, cnt_res, cnt_ve, cnt_vd;
    logic in_job = 1'b0, done_seen, res_seen;

    always @(negedge clk) begin
        logic [31:0] exp_gnt;
        logic        m;
        cyc++;
        if ($countones({ld_sum_enc, ld_sum_dec, ld_results, ld_v_enc, ld_v_dec}) > 1 || gnt == 2'b11)
            viol++;
        if (!in_job && busy) begin
            in_job = 1'b1; grant_cyc = cyc; done_seen = 1'b0; res_seen = 1'b0;
            cnt_se = 0; cnt_sd = 0; cnt_res = 0; cnt_ve = 0; cnt_vd = 0;
            if (sb_q.size() == 0) begin
                check_output("unexpected_grant", {30'd0, gnt}, 32'd0);
            end else begin
                exp_gnt = 32'd1 << sb_q[0].idx;
                check_output("grant_owner", {30'd0, gnt}, exp_gnt);
            end
        end
        if (in_job) begin
            cnt_se += int'(ld_sum_enc); cnt_sd += int'(ld_sum_dec); cnt_res += int'(ld_results);
            cnt_ve += int'(ld_v_enc);   cnt_vd += int'(ld_v_dec);
            if (ld_results && !res_seen) begin
                res_seen = 1'b1;
                if (sb_q.size() > 0 && sb_q[0].mode && sb_q[0].expect_done)
                    check_output("dec_first_res_sum", sum, model_enc_sum(R));
            end
            if (done != 2'b00) begin
                done_seen = 1'b1;
                if (sb_q.size() > 0 && sb_q[0].expect_done) begin
                    m = sb_q[0].mode;
                    exp_gnt = 32'd1 << sb_q[0].idx;
                    check_output("done_bit", {30'd0, done}, exp_gnt);
                    check_output("latency", cyc - grant_cyc, 3 * R);
                    check_output("final_sum", sum, m ? model_dec_final(R) : model_enc_sum(R));
                    check_output("final_round", {26'd0, round}, R);
                    check_output("sum_strobes", m ? cnt_sd : cnt_se, R);
                    check_output("res_strobes", cnt_res, R);
                    check_output("v_strobes", m ? cnt_vd : cnt_ve, R);
                    check_output("wrong_mode_strobes", m ? cnt_se + cnt_ve : cnt_sd + cnt_vd, 0);
                end
            end
            if (!busy) begin
                in_job = 1'b0;
                if (sb_q.size() > 0) begin
                    check_output("done_presence", {31'd0, done_seen}, {31'd0, sb_q[0].expect_done});
                    void'(sb_q.pop_front());
                end
            end
        end else if (done != 2'b00) begin
            viol++;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, "_sum"}, sum, 32'd0);
        check_output({tag, "_round"}, {26'd0, round}, 32'd0);
        check_output({tag, "_done"}, {30'd0, done}, 32'd0);
        check_output({tag, "_strobes"},
                     {27'd0, ld_sum_enc, ld_sum_dec, ld_results, ld_v_enc, ld_v_dec}, 32'd0);
    endtask

    // Issue a request pattern; hold>0 keeps req high for that many jobs, else each bit drops on its done.
    task automatic apply_stimulus(input logic [1:0] pattern, input logic [1:0] modes, input int hold);
        logic [1:0] remaining = pattern;
        int n, w, dones, budget;
        n = (hold > 0) ? hold : $countones(pattern);
        for (int k = 0; k < n; k++) begin
            if (remaining == 2'b11) w = (model_last == 1) ? 0 : 1;
            else w = remaining[1] ? 1 : 0;
            sb_q.push_back('{w, modes[w], 1'b1});
            model_last = w;
            if (hold == 0) remaining[w] = 1'b0;
        end
        req = pattern; req_mode = modes;
        dones = 0; budget = n * (3 * R + 4) + 10;
        while (dones < n && budget > 0) begin
            @(negedge clk); budget--;
            if (done != 2'b00) begin
                dones++;
                if (hold == 0) req = req & ~done;
                else if (dones == n) req = 2'b00;
            end
        end
        if (dones < n) begin
            check_output("job_timeout", dones, n);
            req = 2'b00;
        end
        @(negedge clk);
    endtask

    initial begin
        int budget, n;
        resetn = 1'b0; req = 2'b00; req_mode = 2'b00; abort = 1'b0;
        r1_req = 2'b00; r1_req_mode = 2'b00;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        apply_stimulus(2'b01, 2'b00, 0);
        apply_stimulus(2'b10, 2'b10, 0);
        apply_stimulus(2'b11, 2'b00, 3);

        // Abort an encrypt job once five rounds have completed.
        sb_q.push_back('{0, 1'b0, 1'b0});
        model_last = 0;
        req = 2'b01; req_mode = 2'b00;
        budget = 60;
        while (!(busy && round == 6'd5) && budget > 0) begin
            @(negedge clk); budget--;
        end
        check_output("abort_reach_round5", {26'd0, round}, 32'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("abort");
        sb_q.push_back('{0, 1'b0, 1'b1});
        @(negedge clk);
        check_output("abort_regrant", {30'd0, gnt}, 32'd1);
        budget = 3 * R + 10;
        while (done == 2'b00 && budget > 0) begin
            @(negedge clk); budget--;
        end
        check_output("abort_regrant_done", {30'd0, done}, 32'd1);
        req = 2'b00;
        @(negedge clk);

        repeat (6) begin
            apply_stimulus(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 0);
        end

        // Reset during a decrypt VUPD discards the job.
        sb_q.push_back('{1, 1'b1, 1'b0});
        model_last = 1;
        req = 2'b10; req_mode = 2'b10;
        budget = 20;
        while (!(busy && ld_v_dec) && budget > 0) begin
            @(negedge clk); budget--;
        end
        check_output("reach_dec_vupd", {31'd0, ld_v_dec}, 32'd1);
        #2 resetn = 1'b0;
        #1 check_idle_outputs("midjob_reset");
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_last = 1;
        @(negedge clk);
        apply_stimulus(2'b11, 2'($urandom_range(0, 3)), 0);

        // Single-round instance: done four cycles after the sampling cycle.
        r1_req = 2'b01; r1_req_mode = 2'b00;
        n = 0;
        while (r1_done == 2'b00 && n < 10) begin
            @(negedge clk); n++;
        end
        check_output("r1_latency", n, 32'd4);
        check_output("r1_done", {30'd0, r1_done}, 32'd1);
        check_output("r1_sum", r1_sum, model_enc_sum(1));
        r1_req = 2'b00;
        repeat (3) @(negedge clk);

        check_output("scoreboard_empty", sb_q.size(), 32'd0);
        check_output("protocol_violations", viol, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tea_round_scheduler.md
TEA_ROUND_SCHEDULER -- requirements
Module: tea_round_scheduler

Interface
REQ-001 Parameter ROUNDS, default 32: TEA rounds per job, legal range 1..63.
REQ-002 Parameter DELTA, default 32'h9E3779B9: TEA key-schedule constant.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous and active-low.
REQ-005 req  in  2  request per requester i; held high until done[i].
REQ-006 req_mode  in  2  bit i selects requester i's mode: 0 = encrypt, 1 = decrypt; sampled at grant only.
REQ-007 abort  in  1  cancels the running job.
REQ-008 gnt  out  2  one-hot owner of the round datapath; 00 when idle.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 ld_sum_enc, ld_sum_dec, ld_results, ld_v_enc, ld_v_dec  out  1 each  one-cycle datapath strobes.
REQ-011 sum  out  32  current round sum, registered.
REQ-012 round  out  6  rounds completed in the current job.
REQ-013 done  out  2  one-cycle pulse on bit i when requester i's job completes.

Function
REQ-014 States SHALL be IDLE, SUM, RES, VUPD and DONE; strobes are Moore outputs of these states.
REQ-015 In IDLE with req != 0, the winner SHALL be registered into gnt on the next edge, with round cleared to 0 on the same edge.
REQ-016 If both requests are high, the winner SHALL be the requester not equal to last_gnt; last_gnt updates on every grant.
REQ-017 Encrypt: at grant, sum SHALL be set to 0 and the state SHALL go to SUM; sequence is SUM(ld_sum_enc, sum+=DELTA, round+=1) -> RES(ld_results) -> VUPD(ld_v_enc).
REQ-018 Encrypt: VUPD SHALL go to DONE if round==ROUNDS, else to SUM.
REQ-019 Decrypt: at grant, sum SHALL be set to DELTA*ROUNDS mod 2^32 and the state SHALL go to RES; sequence is RES(ld_results) -> VUPD(ld_v_dec) -> SUM(ld_sum_dec, sum-=DELTA, round+=1).
REQ-020 Decrypt: SUM SHALL go to DONE if round==ROUNDS, else to RES.
REQ-021 All sum arithmetic SHALL be modulo 2^32 (wrap-around, no saturation).
REQ-022 DONE SHALL pulse done[gnt-index] for one cycle, clear gnt the next cycle and return to IDLE; sum and round hold until the next grant.
REQ-023 Latency from the IDLE cycle that samples req to the done pulse SHALL be 3*ROUNDS+1 cycles (97 at default).
REQ-024 A request SHALL NOT be granted in the DONE cycle; the earliest re-grant is decided in the following IDLE cycle.
REQ-025 Deassertion of req[i] mid-job SHALL be ignored; the job runs to completion.
REQ-026 abort high in SUM, RES or VUPD SHALL force IDLE on the next edge with gnt=00, no done pulse, no strobe in that next cycle, and sum and round cleared to 0.
REQ-027 abort in IDLE or DONE SHALL have no effect; abort takes priority over a same-cycle transition to DONE.
REQ-028 At most one strobe SHALL be high in any cycle.

Reset
REQ-029 While resetn=0: state=IDLE, gnt=00, busy=0, all strobes=0, done=00, sum=0, round=0, last_gnt=1 (so requester 0 wins first).
REQ-030 Reset mid-job SHALL discard the job immediately, with no done pulse.

Structure
REQ-031 Package tea_pkg SHALL hold DELTA, the default ROUNDS, the state enumeration and the mode encoding (ENC=0, DEC=1).
REQ-032 The two-way round-robin winner and last_gnt logic SHALL be one sub-module, tea_rr_arb; the FSM, sum and round counter stay in tea_round_scheduler.

Verification
REQ-033 req=01, req_mode=00, default parameters -> gnt=01; done[0] pulses 97 cycles later; final sum=32'hC6EF3720; round=32; 32 of each of ld_sum_enc, ld_results and ld_v_enc.
REQ-034 req=10, req_mode=10 -> sum=32'hC6EF3720 at first RES; ld_results, ld_v_dec and ld_sum_dec each pulse 32 times; final sum=0; done=10.
REQ-035 req=11 right after reset, held high -> gnt=01 first, then gnt=10, then 01; each job asserts its own done bit; no cycle has gnt=11.
REQ-036 Encrypt job, abort pulsed when round=5 -> next cycle IDLE, gnt=00, sum=0, round=0, no done; a still-high req is re-granted in the cycle after that.
REQ-037 resetn low during a decrypt VUPD -> outputs immediately at REQ-029 values; no done pulse; a request after release is granted with last_gnt=1 priority.
REQ-038 ROUNDS=1, encrypt -> done after 4 cycles; sum=32'h9E3779B9.
